// File: rtl/lambda_pkg.sv
// Shared definitions for the lambda result reader: FSM encoding, ASCII constants, default depth.
package lambda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } lambda_state_t;

  localparam int unsigned DEFAULT_DEPTH = 32;

  localparam logic [7:0] ASCII_NUL       = 8'd0;
  localparam logic [7:0] ASCII_SPACE     = 8'd32;
  localparam logic [7:0] ASCII_BACKSLASH = 8'd92;
  localparam logic [7:0] ASCII_DOT       = 8'd46;
  localparam logic [7:0] ASCII_EQUALS    = 8'd61;

endpackage

// File: rtl/lambda_frame_buffer.sv
// Frame storage for the result reader: DEPTH x 8, one synchronous write port, one asynchronous read port.
module lambda_frame_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_25mhz,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Contents are never reset; a frame is always written before it is read.
  always_ff @(posedge clk_25mhz) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lambda_result_reader.sv
// Captures a byte frame terminated by IDLE_BYTE, then drains it over a valid/ready port.
// Build option: LAMBDA_READER_TRIM_SPACE_EN drops ASCII space bytes before capture.
module lambda_result_reader
  import lambda_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter logic [7:0]  IDLE_BYTE = 8'd0,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned PW       = $clog2(DEPTH) + 1
) (
  input  logic          clk_25mhz,
  input  logic          reset_n,
  input  logic [7:0]    data_in,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_done,
  output logic [PW-1:0] frame_len,
  output logic          overflow
);

  lambda_state_t state, state_nxt;
  logic [PW-1:0] count, count_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] frame_len_nxt;
  logic          overflow_nxt;
  logic          out_valid_nxt;
  logic [7:0]    out_data_nxt;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          byte_idle;
  logic          byte_skip;
  logic          accept;
  logic          last_byte;

  assign byte_idle = (data_in == IDLE_BYTE);

`ifdef LAMBDA_READER_TRIM_SPACE_EN
  assign byte_skip = (data_in == ASCII_SPACE);
`else
  assign byte_skip = 1'b0;
`endif

  assign accept    = (state == ST_DRAIN) && out_valid && out_ready;
  assign last_byte = (rd_ptr == (frame_len - PW'(1)));
  // Look one entry ahead on acceptance so back-to-back bytes need no bubble.
  assign rd_addr   = accept ? (rd_ptr[AW-1:0] + AW'(1)) : rd_ptr[AW-1:0];

  lambda_frame_buffer #(.DEPTH(DEPTH)) u_frame_buffer (
    .clk_25mhz (clk_25mhz),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (data_in),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      frame_len <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      rd_ptr    <= rd_ptr_nxt;
      frame_len <= frame_len_nxt;
      overflow  <= overflow_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    rd_ptr_nxt    = rd_ptr;
    frame_len_nxt = frame_len;
    overflow_nxt  = overflow;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    wr_en         = 1'b0;
    wr_addr       = count[AW-1:0];
    unique case (state)
      ST_IDLE: begin
        if (!byte_idle && !byte_skip) begin
          wr_en        = 1'b1;
          wr_addr      = '0;
          count_nxt    = PW'(1);
          overflow_nxt = 1'b0;
          state_nxt    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (byte_idle) begin
          frame_len_nxt = count;
          rd_ptr_nxt    = '0;
          state_nxt     = ST_DRAIN;
        end else if (!byte_skip) begin
          if (count == PW'(DEPTH)) begin
            overflow_nxt = 1'b1;
          end else begin
            wr_en     = 1'b1;
            count_nxt = count + PW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!out_valid) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = rd_data;
        end else if (out_ready) begin
          if (last_byte) begin
            out_valid_nxt = 1'b0;
            state_nxt     = ST_DONE;
          end else begin
            rd_ptr_nxt   = rd_ptr + PW'(1);
            out_data_nxt = rd_data;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_lambda_result_reader.sv
// Scoreboard bench for lambda_result_reader: a DEPTH=32 instance and a DEPTH=4 instance share clock and reset.
module tb_lambda_result_reader;

`ifdef LAMBDA_READER_TRIM_SPACE_EN
  localparam bit TRIM = 1'b1;
`else
  localparam bit TRIM = 1'b0;
`endif

  logic       clk_25mhz = 1'b0;
  logic       reset_n;
  logic [7:0] data_in, data_in4;
  logic       out_ready, out_ready4;
  logic [7:0] out_data, out_data4;
  logic       out_valid, out_valid4;
  logic       frame_done, frame_done4;
  logic [5:0] frame_len;
  logic [2:0] frame_len4;
  logic       overflow, overflow4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  logic [7:0] stim_q[$];
  bit         rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #20 clk_25mhz = ~clk_25mhz;

  lambda_result_reader dut (
    .clk_25mhz  (clk_25mhz),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .overflow   (overflow)
  );

  lambda_result_reader #(.DEPTH(4)) dut4 (
    .clk_25mhz  (clk_25mhz),
    .reset_n    (reset_n),
    .data_in    (data_in4),
    .out_data   (out_data4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .frame_done (frame_done4),
    .frame_len  (frame_len4),
    .overflow   (overflow4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  // Every presented byte must match the head of the scoreboard; it is retired only when accepted.
  always @(negedge clk_25mhz) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) check_val("dut_extra_byte", 32'(exp_q.size()), 32'd1);
      else begin
        check_val("dut_byte", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (reset_n && out_valid4) begin
      if (exp4_q.size() == 0) check_val("dut4_extra_byte", 32'(exp4_q.size()), 32'd1);
      else begin
        check_val("dut4_byte", out_data4, exp4_q[0]);
        if (out_ready4) void'(exp4_q.pop_front());
      end
    end
  end

  // Drives stim_q followed by the idle byte; the model keeps what the reader should store.
  task automatic send_frame(input bit sel);
    int kept = 0;
    foreach (stim_q[i]) begin
      if (sel) begin
        data_in4 = stim_q[i];
        if (kept < 4) exp4_q.push_back(stim_q[i]);
        kept++;
      end else begin
        data_in = stim_q[i];
        if (!(TRIM && stim_q[i] == 8'd32)) begin
          if (kept < 32) exp_q.push_back(stim_q[i]);
          kept++;
        end
      end
      tick();
    end
    if (sel) data_in4 = 8'd0;
    else     data_in  = 8'd0;
    tick();
  endtask

  task automatic wait_done(input bit sel, input bit toggle);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (toggle) begin
        if (sel) out_ready4 = rdy_pat[i % 4];
        else     out_ready  = rdy_pat[i % 4];
      end
      tick();
      seen = sel ? frame_done4 : frame_done;
    end
    check_val(sel ? "dut4_done_seen" : "dut_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      tick();
      check_val(sel ? "dut4_done_pulse" : "dut_done_pulse", 32'(sel ? frame_done4 : frame_done), 32'd0);
    end
    out_ready  = 1'b1;
    out_ready4 = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    data_in    = 8'd0;
    data_in4   = 8'd0;
    out_ready  = 1'b1;
    out_ready4 = 1'b1;
    #50;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_frame_len", 32'(frame_len), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst4_out_valid", 32'(out_valid4), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // " id=\x.x" with a full-rate consumer, including first-byte latency
    stim_q = '{8'd32, 8'd105, 8'd100, 8'd61, 8'd92, 8'd120, 8'd46, 8'd120};
    send_frame(1'b0);
    check_val("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check_val("lat_first_valid", 32'(out_valid), 32'd1);
    check_val("lat_first_byte", 32'(out_data), TRIM ? 32'd105 : 32'd32);
    wait_done(1'b0, 1'b0);
    check_val("lambda_frame_len", 32'(frame_len), TRIM ? 32'd7 : 32'd8);
    check_val("lambda_all_out", 32'(exp_q.size()), 32'd0);
    check_val("lambda_no_overflow", 32'(overflow), 32'd0);

    // consumer stalls with ready pattern 1,0,0,1
    stim_q = '{8'd97, 8'd98, 8'd99, 8'd100};
    send_frame(1'b0);
    wait_done(1'b0, 1'b1);
    check_val("stall_frame_len", 32'(frame_len), 32'd4);
    check_val("stall_all_out", 32'(exp_q.size()), 32'd0);

    // bytes arriving while draining are ignored
    out_ready = 1'b0;
    stim_q = '{8'd49, 8'd50, 8'd51};
    send_frame(1'b0);
    data_in = 8'd72;
    tick();
    data_in = 8'd73;
    tick();
    data_in   = 8'd0;
    out_ready = 1'b1;
    wait_done(1'b0, 1'b0);
    check_val("ignore_frame_len", 32'(frame_len), 32'd3);
    check_val("ignore_all_out", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    check_val("ignore_no_restart", 32'(out_valid), 32'd0);

    // DEPTH=4 overflow, cleared by the next frame
    stim_q = '{8'd65, 8'd66, 8'd67, 8'd68, 8'd69, 8'd70};
    send_frame(1'b1);
    check_val("ovf_set", 32'(overflow4), 32'd1);
    wait_done(1'b1, 1'b0);
    check_val("ovf_frame_len", 32'(frame_len4), 32'd4);
    check_val("ovf_sticky", 32'(overflow4), 32'd1);
    check_val("ovf_all_out", 32'(exp4_q.size()), 32'd0);
    data_in4 = 8'd90;
    exp4_q.push_back(8'd90);
    tick();
    check_val("ovf_cleared", 32'(overflow4), 32'd0);
    data_in4 = 8'd0;
    tick();
    wait_done(1'b1, 1'b0);
    check_val("ovf_next_len", 32'(frame_len4), 32'd1);

    // asynchronous reset while dut4 drains (stalled) and dut captures
    out_ready4 = 1'b0;
    stim_q = '{8'd11, 8'd12};
    send_frame(1'b1);
    tick();
    data_in = 8'd77;
    tick();
    data_in = 8'd78;
    tick();
    data_in = 8'd79;
    tick();
    check_val("pre_rst4_valid", 32'(out_valid4), 32'd1);
    #5;
    reset_n = 1'b0;
    #1;
    check_val("arst_frame_len", 32'(frame_len), 32'd0);
    check_val("arst4_out_valid", 32'(out_valid4), 32'd0);
    check_val("arst4_out_data", 32'(out_data4), 32'd0);
    check_val("arst4_frame_len", 32'(frame_len4), 32'd0);
    exp_q.delete();
    exp4_q.delete();
    data_in    = 8'd0;
    out_ready4 = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    stim_q = '{8'd88};
    send_frame(1'b0);
    wait_done(1'b0, 1'b0);
    check_val("post_rst_frame_len", 32'(frame_len), 32'd1);
    check_val("post_rst_all_out", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
